// File: rtl/frac_ramp_gen_pkg.sv
// Shared types for the fractional ramp generator: run states, config record, widths.
// The FRAC_RAMP_SAT_EN build option changes ALU behaviour only; nothing here depends on it.
package frac_ramp_pkg;

  localparam int DATA_WIDTH = 6;
  localparam int CNT_WIDTH  = 16;
  localparam int FRAC_WIDTH = 4 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  // Sized from the package widths; the top's parameter defaults follow these.
  typedef struct packed {
    logic [FRAC_WIDTH-1:0] start;
    logic [FRAC_WIDTH-1:0] step;
    logic [CNT_WIDTH-1:0]  count;
    logic [CNT_WIDTH-1:0]  dwell;
    logic                  triMode;
  } cfg_t;

  // A dwell of zero behaves as one cycle per value.
  function automatic logic [CNT_WIDTH-1:0] dwellReload(input logic [CNT_WIDTH-1:0] dwell);
    return (dwell == '0) ? '0 : dwell - CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/frac_ramp_gen_if.sv
// Config load channel of the ramp generator: valid/ready handshake plus the run fields.
interface frac_ramp_gen_if
  import frac_ramp_pkg::*;
#(
  parameter int P_DATA_WIDTH = DATA_WIDTH,
  parameter int P_CNT_WIDTH  = CNT_WIDTH
);

  localparam int P_FRAC_WIDTH = 4 * P_DATA_WIDTH;

  logic                    cfgValid;
  logic                    cfgReady;
  logic [P_FRAC_WIDTH-1:0] cfgStart;
  logic [P_FRAC_WIDTH-1:0] cfgStep;
  logic [P_CNT_WIDTH-1:0]  cfgCount;
  logic [P_CNT_WIDTH-1:0]  cfgDwell;
  logic                    cfgTri;

  modport master (
    output cfgValid, cfgStart, cfgStep, cfgCount, cfgDwell, cfgTri,
    input  cfgReady
  );

  modport slave (
    input  cfgValid, cfgStart, cfgStep, cfgCount, cfgDwell, cfgTri,
    output cfgReady
  );

endinterface

// File: rtl/frac_ramp_gen_alu.sv
// Combinational add/subtract of a signed step to the fraction, reporting the next value and a changed flag.
// With FRAC_RAMP_SAT_EN defined the result clamps to [0, 2^W-1]; otherwise it wraps.
module frac_ramp_alu
  import frac_ramp_pkg::*;
#(
  parameter int P_WIDTH = FRAC_WIDTH
) (
  input  logic [P_WIDTH-1:0] frac_i,
  input  logic [P_WIDTH-1:0] step_i,
  input  logic               sub_i,
  output logic [P_WIDTH-1:0] next_o,
  output logic               changed_o
);

`ifdef FRAC_RAMP_SAT_EN
  logic [P_WIDTH:0] ext;
  logic             stepNeg;

  // Out of range exactly when the extra carry/borrow bit disagrees with the step sign.
  always_comb begin
    stepNeg = step_i[P_WIDTH-1];
    ext     = sub_i ? ({1'b0, frac_i} - {1'b0, step_i})
                    : ({1'b0, frac_i} + {1'b0, step_i});
    next_o  = ext[P_WIDTH-1:0];
    if (ext[P_WIDTH] != stepNeg) begin
      next_o = (sub_i ^ stepNeg) ? '0 : '1;
    end
    changed_o = (next_o != frac_i);
  end
`else
  always_comb begin
    next_o    = sub_i ? (frac_i - step_i) : (frac_i + step_i);
    changed_o = 1'b1;
  end
`endif

endmodule

// File: rtl/frac_ramp_gen.sv
// Fractional-word ramp sequencer (sawtooth or triangle) driving the MASH segment inputs MSB-first.
// Optional FRAC_RAMP_SAT_EN selects saturating arithmetic in the ALU.
module frac_ramp_gen
  import frac_ramp_pkg::*;
#(
  parameter int P_DATA_WIDTH = DATA_WIDTH,
  parameter int P_CNT_WIDTH  = CNT_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  frac_ramp_gen_if.slave          cfgBus,
  input  logic                    i_start,
  input  logic                    i_abort,
  output logic [P_DATA_WIDTH-1:0] o_msb,
  output logic [P_DATA_WIDTH-1:0] o_isb1,
  output logic [P_DATA_WIDTH-1:0] o_isb2,
  output logic [P_DATA_WIDTH-1:0] o_lsb,
  output logic                    o_busy,
  output logic                    o_update,
  output logic                    o_done
);

  localparam int P_FRAC_WIDTH = 4 * P_DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [P_FRAC_WIDTH-1:0] frac_q, frac_d;
  cfg_t                    shadow_q, shadow_d;
  logic [P_FRAC_WIDTH-1:0] runStep_q, runStep_d;
  logic [P_CNT_WIDTH-1:0]  runCount_q, runCount_d;
  logic [P_CNT_WIDTH-1:0]  reload_q, reload_d;
  logic                    runTri_q, runTri_d;
  logic [P_CNT_WIDTH-1:0]  dwellCnt_q, dwellCnt_d;
  logic [P_CNT_WIDTH-1:0]  stepCnt_q, stepCnt_d;
  logic                    update_q, update_d;
  logic                    done_q, done_d;

  logic                    aluSub;
  logic [P_FRAC_WIDTH-1:0] aluNext;
  logic                    aluChanged;

  // The last UP value with steps left still adds; with none left the triangle turn subtracts.
  assign aluSub = (state_q == DOWN) || (stepCnt_q == '0);

  frac_ramp_alu #(.P_WIDTH(P_FRAC_WIDTH)) uAlu (
    .frac_i   (frac_q),
    .step_i   (runStep_q),
    .sub_i    (aluSub),
    .next_o   (aluNext),
    .changed_o(aluChanged)
  );

  always_comb begin
    state_d    = state_q;
    frac_d     = frac_q;
    shadow_d   = shadow_q;
    runStep_d  = runStep_q;
    runCount_d = runCount_q;
    reload_d   = reload_q;
    runTri_d   = runTri_q;
    dwellCnt_d = dwellCnt_q;
    stepCnt_d  = stepCnt_q;
    update_d   = 1'b0;
    done_d     = 1'b0;

    if (cfgBus.cfgValid && (state_q == IDLE)) begin
      shadow_d = '{start:   cfgBus.cfgStart,
                   step:    cfgBus.cfgStep,
                   count:   cfgBus.cfgCount,
                   dwell:   cfgBus.cfgDwell,
                   triMode: cfgBus.cfgTri};
    end

    case (state_q)
      IDLE: begin
        // Run fields are copied out so a config loaded on the start edge waits for the next run.
        if (i_start) begin
          state_d    = UP;
          frac_d     = shadow_q.start;
          runStep_d  = shadow_q.step;
          runCount_d = shadow_q.count;
          runTri_d   = shadow_q.triMode;
          reload_d   = dwellReload(shadow_q.dwell);
          dwellCnt_d = dwellReload(shadow_q.dwell);
          stepCnt_d  = shadow_q.count;
          update_d   = 1'b1;
        end
      end
      UP, DOWN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (dwellCnt_q != '0) begin
          dwellCnt_d = dwellCnt_q - P_CNT_WIDTH'(1);
        end else begin
          dwellCnt_d = reload_q;
          if (stepCnt_q != '0) begin
            frac_d    = aluNext;
            update_d  = aluChanged;
            stepCnt_d = stepCnt_q - P_CNT_WIDTH'(1);
          end else if ((state_q == UP) && runTri_q) begin
            // The first down step is taken on the turn so the peak is held only once.
            state_d   = DOWN;
            stepCnt_d = '0;
            if (runCount_q != '0) begin
              frac_d    = aluNext;
              update_d  = aluChanged;
              stepCnt_d = runCount_q - P_CNT_WIDTH'(1);
            end
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      frac_q     <= '0;
      shadow_q   <= '0;
      runStep_q  <= '0;
      runCount_q <= '0;
      reload_q   <= '0;
      runTri_q   <= 1'b0;
      dwellCnt_q <= '0;
      stepCnt_q  <= '0;
      update_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frac_q     <= frac_d;
      shadow_q   <= shadow_d;
      runStep_q  <= runStep_d;
      runCount_q <= runCount_d;
      reload_q   <= reload_d;
      runTri_q   <= runTri_d;
      dwellCnt_q <= dwellCnt_d;
      stepCnt_q  <= stepCnt_d;
      update_q   <= update_d;
      done_q     <= done_d;
    end
  end

  assign cfgBus.cfgReady = (state_q == IDLE);
  assign o_busy          = (state_q != IDLE);
  assign o_update        = update_q;
  assign o_done          = done_q;
  assign o_msb           = frac_q[4*P_DATA_WIDTH-1:3*P_DATA_WIDTH];
  assign o_isb1          = frac_q[3*P_DATA_WIDTH-1:2*P_DATA_WIDTH];
  assign o_isb2          = frac_q[2*P_DATA_WIDTH-1:P_DATA_WIDTH];
  assign o_lsb           = frac_q[P_DATA_WIDTH-1:0];

endmodule

// File: tb/tb_frac_ramp_gen.sv
// Directed self-checking bench for frac_ramp_gen in the default (wrap-around) build.
module tb_frac_ramp_gen;
  import frac_ramp_pkg::*;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_abort;
  logic [5:0] o_msb, o_isb1, o_isb2, o_lsb;
  logic       o_busy, o_update, o_done;

  frac_ramp_gen_if cfgIf ();

  frac_ramp_gen dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .cfgBus  (cfgIf),
    .i_start (i_start),
    .i_abort (i_abort),
    .o_msb   (o_msb),
    .o_isb1  (o_isb1),
    .o_isb2  (o_isb2),
    .o_lsb   (o_lsb),
    .o_busy  (o_busy),
    .o_update(o_update),
    .o_done  (o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [23:0] start;
    logic [23:0] step;
    logic [15:0] count;
    logic [15:0] dwell;
    logic        triMode;
    int          expBusy;
    int          expUpd;
    logic [23:0] expFinal;
  } vec_t;

  vec_t        vecs[6];
  int          checks;
  int          errors;
  logic [23:0] vals[$];
  int          busyN, updN, doneN;
  logic [23:0] fin;

  function automatic logic [23:0] curFrac();
    return {o_msb, o_isb1, o_isb2, o_lsb};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] start, input logic [23:0] step,
                               input logic [15:0] count, input logic [15:0] dwell,
                               input logic triMode);
    @(negedge i_clk);
    cfgIf.cfgStart = start;
    cfgIf.cfgStep  = step;
    cfgIf.cfgCount = count;
    cfgIf.cfgDwell = dwell;
    cfgIf.cfgTri   = triMode;
    cfgIf.cfgValid = 1'b1;
    @(negedge i_clk);
    cfgIf.cfgValid = 1'b0;
  endtask

  task automatic startRun();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  // Entered at the first negedge after the start edge; samples every cycle until idle.
  task automatic measureRun(output int nBusy, output int nUpd, output int nDone,
                            output logic [23:0] finalFrac);
    int guard;
    nBusy = 0;
    nUpd  = 0;
    nDone = 0;
    guard = 0;
    vals.delete();
    while (o_busy && guard < 2000) begin
      vals.push_back(curFrac());
      if (o_update) nUpd++;
      if (o_done) nDone++;
      nBusy++;
      guard++;
      @(negedge i_clk);
    end
    checkOutput("run_bounded", {31'b0, guard >= 2000}, 32'd0);
    if (o_update) nUpd++;
    if (o_done) nDone++;
    finalFrac = curFrac();
    @(negedge i_clk);
    if (o_update) nUpd++;
    if (o_done) nDone++;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (o_busy && guard < 2000) begin
      guard++;
      @(negedge i_clk);
    end
    checkOutput("idle_bounded", {31'b0, guard >= 2000}, 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    i_rst_n         = 1'b0;
    i_start         = 1'b0;
    i_abort         = 1'b0;
    cfgIf.cfgValid  = 1'b0;
    cfgIf.cfgStart  = '0;
    cfgIf.cfgStep   = '0;
    cfgIf.cfgCount  = '0;
    cfgIf.cfgDwell  = '0;
    cfgIf.cfgTri    = 1'b0;

    vecs[0] = '{24'h000100, 24'h000010, 16'd3, 16'd4, 1'b0, 16, 4, 24'h000130};
    vecs[1] = '{24'hFFFFF0, 24'h000010, 16'd2, 16'd0, 1'b1, 5,  5, 24'hFFFFF0};
    vecs[2] = '{24'h000020, 24'hFFFFF0, 16'd2, 16'd1, 1'b0, 3,  3, 24'h000000};
    vecs[3] = '{24'h123456, 24'h000005, 16'd0, 16'd3, 1'b0, 3,  1, 24'h123456};
    vecs[4] = '{24'hABCDEF, 24'h000007, 16'd0, 16'd2, 1'b1, 4,  1, 24'hABCDEF};
    vecs[5] = '{24'h000010, 24'h000008, 16'd1, 16'd2, 1'b1, 6,  3, 24'h000010};

    #12;
    checkOutput("rst_busy",   {31'b0, o_busy},         32'd0);
    checkOutput("rst_ready",  {31'b0, cfgIf.cfgReady}, 32'd1);
    checkOutput("rst_update", {31'b0, o_update},       32'd0);
    checkOutput("rst_done",   {31'b0, o_done},         32'd0);
    checkOutput("rst_frac",   {8'b0, curFrac()},       32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].start, vecs[v].step, vecs[v].count, vecs[v].dwell, vecs[v].triMode);
      startRun();
      measureRun(busyN, updN, doneN, fin);
      checkOutput($sformatf("vec%0d_busy", v),   busyN,           vecs[v].expBusy);
      checkOutput($sformatf("vec%0d_update", v), updN,            vecs[v].expUpd);
      checkOutput($sformatf("vec%0d_done", v),   doneN,           32'd1);
      checkOutput($sformatf("vec%0d_final", v),  {8'b0, fin},     {8'b0, vecs[v].expFinal});
    end

    // Sawtooth per-cycle values and segment split.
    applyStimulus(24'h000100, 24'h000010, 16'd3, 16'd4, 1'b0);
    startRun();
    checkOutput("saw_first_msb", {26'b0, o_msb},  32'h00);
    checkOutput("saw_first_lsb", {26'b0, o_lsb},  32'h00);
    checkOutput("saw_first_isb2", {26'b0, o_isb2}, 32'h04);
    measureRun(busyN, updN, doneN, fin);
    checkOutput("saw_c3",  {8'b0, vals[3]},  32'h000100);
    checkOutput("saw_c4",  {8'b0, vals[4]},  32'h000110);
    checkOutput("saw_c8",  {8'b0, vals[8]},  32'h000120);
    checkOutput("saw_c15", {8'b0, vals[15]}, 32'h000130);
    checkOutput("saw_lsb_end", {26'b0, o_lsb}, 32'h30);

    // Triangle with wrap, one value per cycle.
    applyStimulus(24'hFFFFF0, 24'h000010, 16'd2, 16'd0, 1'b1);
    startRun();
    measureRun(busyN, updN, doneN, fin);
    checkOutput("tri_v0", {8'b0, vals[0]}, 32'hFFFFF0);
    checkOutput("tri_v1", {8'b0, vals[1]}, 32'h000000);
    checkOutput("tri_v2", {8'b0, vals[2]}, 32'h000010);
    checkOutput("tri_v3", {8'b0, vals[3]}, 32'h000000);
    checkOutput("tri_v4", {8'b0, vals[4]}, 32'hFFFFF0);

    // Negative step sequence.
    applyStimulus(24'h000020, 24'hFFFFF0, 16'd2, 16'd1, 1'b0);
    startRun();
    measureRun(busyN, updN, doneN, fin);
    checkOutput("neg_v0", {8'b0, vals[0]}, 32'h000020);
    checkOutput("neg_v1", {8'b0, vals[1]}, 32'h000010);
    checkOutput("neg_v2", {8'b0, vals[2]}, 32'h000000);

    // Abort in busy cycle 6 of the sawtooth.
    applyStimulus(24'h000100, 24'h000010, 16'd3, 16'd4, 1'b0);
    startRun();
    repeat (5) @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    checkOutput("abort_busy",   {31'b0, o_busy},         32'd0);
    checkOutput("abort_done",   {31'b0, o_done},         32'd0);
    checkOutput("abort_update", {31'b0, o_update},       32'd0);
    checkOutput("abort_ready",  {31'b0, cfgIf.cfgReady}, 32'd1);
    checkOutput("abort_frac",   {8'b0, curFrac()},       32'h000110);
    @(negedge i_clk);
    checkOutput("abort_no_done_later", {31'b0, o_done}, 32'd0);

    // Config offered while busy is refused.
    startRun();
    cfgIf.cfgStart = 24'h000777;
    cfgIf.cfgStep  = 24'h000001;
    cfgIf.cfgCount = 16'd0;
    cfgIf.cfgDwell = 16'd0;
    cfgIf.cfgTri   = 1'b0;
    cfgIf.cfgValid = 1'b1;
    checkOutput("busy_ready", {31'b0, cfgIf.cfgReady}, 32'd0);
    repeat (3) @(negedge i_clk);
    cfgIf.cfgValid = 1'b0;
    waitIdle();
    startRun();
    measureRun(busyN, updN, doneN, fin);
    checkOutput("nocap_first", {8'b0, vals[0]}, 32'h000100);
    checkOutput("nocap_busy",  busyN,           32'd16);

    // Config and start on the same edge: old config now, new config next.
    @(negedge i_clk);
    cfgIf.cfgStart = 24'h000555;
    cfgIf.cfgStep  = 24'h000001;
    cfgIf.cfgCount = 16'd1;
    cfgIf.cfgDwell = 16'd1;
    cfgIf.cfgTri   = 1'b0;
    cfgIf.cfgValid = 1'b1;
    i_start        = 1'b1;
    @(negedge i_clk);
    cfgIf.cfgValid = 1'b0;
    i_start        = 1'b0;
    measureRun(busyN, updN, doneN, fin);
    checkOutput("same_old_final", {8'b0, fin}, 32'h000130);
    checkOutput("same_old_busy",  busyN,       32'd16);
    startRun();
    measureRun(busyN, updN, doneN, fin);
    checkOutput("same_new_first", {8'b0, vals[0]}, 32'h000555);
    checkOutput("same_new_final", {8'b0, fin},     32'h000556);
    checkOutput("same_new_busy",  busyN,           32'd2);

    // Asynchronous reset between edges during a run.
    applyStimulus(24'h000100, 24'h000010, 16'd3, 16'd4, 1'b0);
    startRun();
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("arst_busy",  {31'b0, o_busy},         32'd0);
    checkOutput("arst_ready", {31'b0, cfgIf.cfgReady}, 32'd1);
    checkOutput("arst_frac",  {8'b0, curFrac()},       32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    startRun();
    measureRun(busyN, updN, doneN, fin);
    checkOutput("arst_run_busy",  busyN,       32'd1);
    checkOutput("arst_run_done",  doneN,       32'd1);
    checkOutput("arst_run_final", {8'b0, fin}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
